softusb_navre_iomon: RTL and testbench

Synthesizable, parametrised I/O monitor on the softusb_navre I/O bus. It captures CPU byte writes to a window of I/O addresses into one FIFO per channel, detects per-channel end-of-stream markers, and enforces a cycle-limit watchdog. Captured bytes are drained through a side port by a host or checker. It supersedes the single-port, single-stream, simulation-only output capture used by the CPU benches.

---
 rtl/softusb_navre_iomon.sv | 187 ++++++++++++++++++
 tb/tb_softusb_navre_iomon.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/softusb_navre_iomon.sv
// I/O monitor for the softusb_navre bus: captures CPU byte writes to a window
// of I/O addresses into per-channel FIFOs, tracks end-of-stream (zero byte)
// and overflow per channel, runs a cycle-limit watchdog, and exposes the
// captured bytes through a drain port.

// Per-channel byte FIFO: circular pointers plus an occupancy counter.
module softusb_navre_iomon_fifo #(
    parameter int AW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LP_ONE_O = (AW+1)'(1);
    localparam logic [AW-1:0] LP_ONE_P = AW'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_occ;
    logic          w_do_pop, w_do_push;

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
    // when a pop frees the slot in the same cycle.
    assign empty     = (r_occ == '0);
    assign full      = (r_occ == LP_DEPTH);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rp];

    // Storage: contents are not reset, the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wp] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_occ <= '0;
        end else if (clear) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_occ <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + LP_ONE_P;
            if (w_do_pop)  r_rp <= r_rp + LP_ONE_P;
            case ({w_do_push, w_do_pop})
                2'b10:   r_occ <= r_occ + LP_ONE_O;
                2'b01:   r_occ <= r_occ - LP_ONE_O;
                default: r_occ <= r_occ;
            endcase
        end
    end
endmodule

module softusb_navre_iomon #(
    parameter int CHANNELS    = 2,
    parameter int BASE_ADDR   = 42,
    parameter int FIFO_AW     = 4,
    parameter int LIMIT_W     = 16,
    parameter int CYCLE_LIMIT = 10000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                io_re,
    input  logic                io_we,
    input  logic [5:0]          io_a,
    input  logic [7:0]          io_do,
    output logic [7:0]          io_di,
    input  logic [1:0]          drain_ch,
    input  logic                drain_en,
    output logic [7:0]          drain_data,
    output logic                drain_valid,
    output logic [CHANNELS-1:0] eof,
    output logic [CHANNELS-1:0] overflow,
    output logic                timeout,
    output logic                done
);
    localparam logic [5:0]         LP_STAT  = 6'(BASE_ADDR + CHANNELS);
    localparam logic [LIMIT_W-1:0] LP_LIMIT = LIMIT_W'(CYCLE_LIMIT);
    localparam logic [LIMIT_W-1:0] LP_ONE   = LIMIT_W'(1);

    logic [CHANNELS-1:0]      w_push, w_zero_wr, w_pop, w_empty, w_full;
    logic [CHANNELS-1:0][7:0] w_dout;
    logic [7:0]               w_sel, w_status;
    logic [LIMIT_W-1:0]       w_cyc_nxt;

    logic [7:0]          r_io_di, r_drain_data;
    logic                r_drain_valid, r_timeout, r_done;
    logic [CHANNELS-1:0] r_eof, r_ovf;
    logic [LIMIT_W-1:0]  r_cyc;

    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : g_ch
            localparam logic [5:0] LP_ADDR = 6'(BASE_ADDR + c);
            logic w_hit;
            assign w_hit        = io_we && (io_a == LP_ADDR);
            assign w_push[c]    = w_hit && (io_do != 8'h00);
            assign w_zero_wr[c] = w_hit && (io_do == 8'h00);
            assign w_pop[c]     = drain_en && (drain_ch == 2'(c)) && !w_empty[c];

            softusb_navre_iomon_fifo #(.AW(FIFO_AW)) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .clear (clear),
                .push  (w_push[c]),
                .pop   (w_pop[c]),
                .din   (io_do),
                .dout  (w_dout[c]),
                .empty (w_empty[c]),
                .full  (w_full[c])
            );
        end
    endgenerate

    // Drain mux: at most one channel pops per cycle.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_pop[i]) w_sel = w_dout[i];
        end
    end

    // Status register: not-empty in the low nibble, eof in the high nibble.
    always_comb begin
        w_status = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_status[i]     = !w_empty[i];
            w_status[4 + i] = r_eof[i];
        end
    end

    // Watchdog count saturates at the limit.
    assign w_cyc_nxt = (r_cyc == LP_LIMIT) ? r_cyc : r_cyc + LP_ONE;

    // Registered outputs, sticky flags and watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_io_di       <= '0;
            r_drain_data  <= '0;
            r_drain_valid <= 1'b0;
            r_eof         <= '0;
            r_ovf         <= '0;
            r_timeout     <= 1'b0;
            r_done        <= 1'b0;
            r_cyc         <= '0;
        end else if (clear) begin
            r_io_di       <= '0;
            r_drain_data  <= '0;
            r_drain_valid <= 1'b0;
            r_eof         <= '0;
            r_ovf         <= '0;
            r_timeout     <= 1'b0;
            r_done        <= 1'b0;
            r_cyc         <= '0;
        end else begin
            r_io_di       <= (io_re && io_a == LP_STAT) ? w_status : 8'h00;
            r_drain_valid <= |w_pop;
            if (|w_pop) r_drain_data <= w_sel;
            r_eof         <= r_eof | w_zero_wr;
            // A push into a full FIFO is only dropped when no pop frees a slot.
            r_ovf         <= r_ovf | (w_push & w_full & ~w_pop);
            r_cyc         <= w_cyc_nxt;
            r_timeout     <= r_timeout | (w_cyc_nxt == LP_LIMIT);
            r_done        <= (&r_eof) | r_timeout;
        end
    end

    assign io_di       = r_io_di;
    assign drain_data  = r_drain_data;
    assign drain_valid = r_drain_valid;
    assign eof         = r_eof;
    assign overflow    = r_ovf;
    assign timeout     = r_timeout;
    assign done        = r_done;
endmodule

// File: tb/tb_softusb_navre_iomon.sv
// Bench for softusb_navre_iomon: queue-based reference model updated once per
// clock, compared against the DUT 1 time unit after each rising edge, plus
// directed scenarios with literal expectations.
module tb_softusb_navre_iomon;
    localparam int CH    = 2;
    localparam int BASE  = 42;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int LIM   = 100;

    logic clk = 1'b0, rst = 1'b0, clear = 1'b0, io_re = 1'b0, io_we = 1'b0;
    logic [5:0] io_a = '0;
    logic [7:0] io_do = '0;
    logic [1:0] drain_ch = '0;
    logic drain_en = 1'b0;
    logic [7:0] io_di, drain_data;
    logic drain_valid, timeout, done;
    logic [CH-1:0] eof, overflow;

    softusb_navre_iomon #(.CHANNELS(CH), .BASE_ADDR(BASE), .FIFO_AW(AW),
                          .LIMIT_W(16), .CYCLE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .clear(clear), .io_re(io_re), .io_we(io_we),
        .io_a(io_a), .io_do(io_do), .io_di(io_di), .drain_ch(drain_ch),
        .drain_en(drain_en), .drain_data(drain_data), .drain_valid(drain_valid),
        .eof(eof), .overflow(overflow), .timeout(timeout), .done(done));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    // reference model state
    logic [7:0]    mq [CH][$];
    logic [CH-1:0] m_eof, m_ovf;
    logic          m_to, m_done, m_dv, m_di_chk;
    logic [7:0]    m_dd, m_di;
    int            m_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) mq[c].delete();
        m_eof = '0; m_ovf = '0; m_to = 0; m_done = 0; m_dv = 0;
        m_dd = '0; m_di = '0; m_di_chk = 1; m_cyc = 0;
    endtask

    task automatic idle();
        io_re = 0; io_we = 0; io_a = '0; io_do = '0; drain_en = 0; drain_ch = '0; clear = 0;
    endtask

    // Advance model and DUT by one clock, then compare every meaningful output.
    task automatic step();
        logic [7:0] st;
        logic [CH-1:0] e_prev;
        logic to_prev;
        int c;
        if (clear) begin
            model_reset();
        end else begin
            e_prev = m_eof; to_prev = m_to;
            st = '0;
            for (int i = 0; i < CH; i++) begin
                st[i] = (mq[i].size() != 0);
                st[4+i] = m_eof[i];
            end
            m_di_chk = io_re;
            m_di = (io_re && io_a == BASE + CH) ? st : 8'h00;
            m_dv = 0;
            if (drain_en && drain_ch < CH && mq[drain_ch].size() > 0) begin
                m_dd = mq[drain_ch].pop_front();
                m_dv = 1;
            end
            if (io_we && io_a >= BASE && io_a < BASE + CH) begin
                c = int'(io_a) - BASE;
                if (io_do == 8'h00) m_eof[c] = 1'b1;
                else if (mq[c].size() < DEPTH) mq[c].push_back(io_do);
                else m_ovf[c] = 1'b1;
            end
            m_done = (&e_prev) | to_prev;
            if (m_cyc < LIM) m_cyc++;
            if (m_cyc == LIM) m_to = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("drain_valid", drain_valid, m_dv);
        if (m_dv) chk("drain_data", drain_data, m_dd);
        if (m_di_chk) chk("io_di", io_di, m_di);
        chk("eof", eof, m_eof);
        chk("overflow", overflow, m_ovf);
        chk("timeout", timeout, m_to);
        chk("done", done, m_done);
    endtask

    task automatic do_clear();
        idle(); clear = 1; step(); clear = 0;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        idle(); io_we = 1; io_a = 6'(a); io_do = d; step(); idle();
    endtask

    task automatic pop(input int ch);
        idle(); drain_en = 1; drain_ch = 2'(ch); step(); idle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_io_di"}, io_di, 0);
        chk({tag, "_drain_data"}, drain_data, 0);
        chk({tag, "_drain_valid"}, drain_valid, 0);
        chk({tag, "_eof"}, eof, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        model_reset();
        #1;
        chk_all_zero("reset");
        #11 rst = 1;

        // single channel stream
        do_clear();
        wr(42, 8'h02); wr(42, 8'h03); wr(42, 8'h05); wr(42, 8'h00);
        chk("t1_eof", eof, 2'b01);
        chk("t1_done", done, 0);
        pop(0); chk("t1_d0", drain_data, 8'h02); chk("t1_v0", drain_valid, 1);
        pop(0); chk("t1_d1", drain_data, 8'h03);
        pop(0); chk("t1_d2", drain_data, 8'h05);
        pop(0); chk("t1_v3", drain_valid, 0);

        // overflow
        do_clear();
        for (int i = 1; i <= 17; i++) wr(43, 8'(i));
        chk("t2_ovf", overflow, 2'b10);
        for (int i = 1; i <= 16; i++) begin
            pop(1); chk("t2_drain", drain_data, 32'(i));
        end
        pop(1); chk("t2_empty", drain_valid, 0);

        // full FIFO, simultaneous push and pop
        do_clear();
        for (int i = 0; i < 16; i++) wr(42, 8'(8'h10 + i));
        idle(); io_we = 1; io_a = 6'd42; io_do = 8'hAA; drain_en = 1; drain_ch = 2'd0;
        step(); idle();
        chk("t3_oldest", drain_data, 8'h10);
        chk("t3_noovf", overflow, 2'b00);
        for (int i = 0; i < 16; i++) pop(0);
        chk("t3_last", drain_data, 8'hAA);
        pop(0); chk("t3_empty", drain_valid, 0);

        // status read
        do_clear();
        wr(42, 8'h07); wr(43, 8'h00);
        idle(); io_re = 1; io_a = 6'd44; step(); idle();
        chk("t4_status", io_di, 8'h21);
        idle(); io_re = 1; io_a = 6'd10; step(); idle();
        chk("t4_other", io_di, 8'h00);

        // watchdog
        do_clear();
        for (int k = 1; k <= 101; k++) begin
            step();
            chk("t5_timeout", timeout, (k >= 100) ? 1 : 0);
            chk("t5_done", done, (k >= 101) ? 1 : 0);
        end
        do_clear();
        chk_all_zero("t5_clear");
        for (int k = 1; k <= 100; k++) begin
            step();
            if (k >= 99) chk("t5_recur", timeout, (k == 100) ? 1 : 0);
        end

        // async reset mid-stream
        do_clear();
        for (int i = 1; i <= 5; i++) wr(42, 8'(i));
        wr(42, 8'h00); wr(43, 8'h00);
        idle(); drain_en = 1; drain_ch = 2'd0; step(); idle();
        #2 rst = 0;
        #1;
        chk_all_zero("t6_async");
        model_reset();
        #3 rst = 1;
        pop(0);
        chk("t6_after", drain_valid, 0);

        // randomized traffic
        do_clear();
        for (int n = 0; n < 3000; n++) begin
            int popp;
            idle();
            popp = ((n / 200) % 2 == 0) ? 20 : 70;
            io_we = ($urandom_range(99) < 60);
            case ($urandom_range(7))
                0, 1, 2: io_a = 6'd42;
                3, 4:    io_a = 6'd43;
                5:       io_a = 6'd44;
                6:       io_a = 6'd41;
                default: io_a = 6'($urandom_range(63));
            endcase
            io_do = ($urandom_range(15) == 0) ? 8'h00 : 8'($urandom_range(255));
            io_re = ($urandom_range(3) == 0);
            drain_en = ($urandom_range(99) < popp);
            drain_ch = ($urandom_range(9) == 0) ? 2'($urandom_range(3)) : 2'($urandom_range(1));
            clear = ($urandom_range(299) == 0);
            step();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
